fu_join_2_1: RTL and testbench

Two-operand join buffer that sits directly upstream of the two-input ALU functional unit in the CGRA datapath. It accepts operands on two independent valid/ready channels, queues each in a small FIFO, and presents a matched operand pair to the ALU's `in0`/`in1` only when both are available and the consumer is ready. It also supports a sticky-constant mode for `in1`, so loop-invariant operands are captured once and reused on every firing.

---
 rtl/fu_join_2_1_pkg.sv | 12 +
 rtl/fu_join_2_1_opnd_fifo.sv | 63 ++++++
 rtl/fu_join_2_1.sv | 110 +++++++++++
 tb/tb_fu_join_2_1.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_join_2_1_pkg.sv
// Shared definitions for the two-operand join buffer in front of the ALU.
// Holds the config encodings and the default operand width and FIFO depth.
package fu_join_2_1_pkg;

    localparam logic [1:0] CFG_NORMAL = 2'd0;
    localparam logic [1:0] CFG_SINGLE = 2'd1;
    localparam logic [1:0] CFG_STICKY = 2'd2;

    localparam int DEFAULT_SIZE  = 32;
    localparam int DEFAULT_DEPTH = 2;

endpackage

// File: rtl/fu_join_2_1_opnd_fifo.sv
// Small synchronous operand FIFO with push/pop, full/empty flags and a
// synchronous active-low clear that also wipes the storage.
module fu_opnd_fifo
    import fu_join_2_1_pkg::*;
#(
    parameter int width = DEFAULT_SIZE,
    parameter int depth = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [width-1:0] mem_r [depth];
    logic             do_push_s;
    logic             do_pop_s;

    // Flag, head and guarded handshake decode
    always_comb begin
        full      = (count_r == CW'(depth));
        empty     = (count_r == {CW{1'b0}});
        head      = mem_r[rd_ptr_r];
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
    end

    // Pointer, occupancy and storage update; pointers wrap since depth is a power of two
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < depth; i++) begin
                mem_r[i] <= {width{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fu_join_2_1.sv
// Two-operand join buffer: queues ALU operands on independent channels and
// releases a matched pair; supports single-operand and sticky-in1 modes.
module fu_join_2_1
    import fu_join_2_1_pkg::*;
#(
    parameter int size  = DEFAULT_SIZE,
    parameter int depth = DEFAULT_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      config_sig,
    input  logic [size-1:0] in0,
    input  logic            in0_valid,
    output logic            in0_ready,
    input  logic [size-1:0] in1,
    input  logic            in1_valid,
    output logic            in1_ready,
    output logic [size-1:0] out0,
    output logic [size-1:0] out1,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [size-1:0] head0_s;
    logic [size-1:0] head1_s;
    logic            full0_s, empty0_s;
    logic            full1_s, empty1_s;
    logic            push0_s, push1_s, pop0_s, pop1_s;
    logic            sticky_load_s;
    logic            fire_s;
    logic            held_r;
    logic [size-1:0] sticky_r;

    fu_opnd_fifo #(.width(size), .depth(depth)) u_fifo0 (
        .clk   (clk),
        .clr_n (rst_n),
        .push  (push0_s),
        .pop   (pop0_s),
        .din   (in0),
        .head  (head0_s),
        .full  (full0_s),
        .empty (empty0_s)
    );

    fu_opnd_fifo #(.width(size), .depth(depth)) u_fifo1 (
        .clk   (clk),
        .clr_n (rst_n),
        .push  (push1_s),
        .pop   (pop1_s),
        .din   (in1),
        .head  (head1_s),
        .full  (full1_s),
        .empty (empty1_s)
    );

    // Mode-dependent join: readies never look at out_ready, and everything is gated by rst_n
    always_comb begin
        in0_ready     = rst_n & ~full0_s;
        in1_ready     = 1'b0;
        out_valid     = 1'b0;
        out0          = head0_s;
        out1          = {size{1'b0}};
        push0_s       = in0_valid & in0_ready;
        push1_s       = 1'b0;
        sticky_load_s = 1'b0;
        fire_s        = 1'b0;
        pop0_s        = 1'b0;
        pop1_s        = 1'b0;
        case (config_sig)
            CFG_NORMAL: begin
                in1_ready = rst_n & ~full1_s;
                out_valid = rst_n & ~empty0_s & ~empty1_s;
                out1      = head1_s;
                push1_s   = in1_valid & in1_ready;
                fire_s    = out_valid & out_ready;
                pop0_s    = fire_s;
                pop1_s    = fire_s;
            end
            CFG_STICKY: begin
                // The invariant operand bypasses FIFO1 and is captured once
                in1_ready     = rst_n & ~held_r;
                out_valid     = rst_n & ~empty0_s & held_r;
                out1          = sticky_r;
                sticky_load_s = in1_valid & in1_ready;
                fire_s        = out_valid & out_ready;
                pop0_s        = fire_s;
            end
            default: begin
                out_valid = rst_n & ~empty0_s;
                fire_s    = out_valid & out_ready;
                pop0_s    = fire_s;
            end
        endcase
    end

    // Sticky operand capture; held until the next reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_r   <= 1'b0;
            sticky_r <= {size{1'b0}};
        end else if (sticky_load_s) begin
            held_r   <= 1'b1;
            sticky_r <= in1;
        end else begin
            held_r   <= held_r;
            sticky_r <= sticky_r;
        end
    end

endmodule

// File: tb/tb_fu_join_2_1.sv
// Self-checking bench for fu_join_2_1: an independent operand model feeds a
// scoreboard that is compared against fired pairs in each scenario task.
module tb_fu_join_2_1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  config_sig;
    logic [31:0] in0, in1, out0, out1;
    logic        in0_valid, in1_valid, in0_ready, in1_ready;
    logic        out_valid, out_ready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] m0[$];
    logic [31:0] m1[$];
    logic        s_held;
    logic [31:0] s_val;
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    int          obs_cyc[$];

    fu_join_2_1 #(.size(32), .depth(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .config_sig (config_sig),
        .in0        (in0),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in1        (in1),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .out0       (out0),
        .out1       (out1),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One cycle: record any fire with its expected pair, update the model, advance to next negedge
    task automatic tick();
        int n0, n1;
        logic [31:0] a, b;
        #1;
        n0 = m0.size();
        n1 = m1.size();
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            obs_q.push_back({out0, out1});
            obs_cyc.push_back(cyc);
            if (n0 == 0) begin
                exp_q.push_back(64'bx);
            end else if (config_sig[0]) begin
                a = m0.pop_front();
                exp_q.push_back({a, 32'd0});
            end else if (config_sig == 2'd2) begin
                a = m0.pop_front();
                exp_q.push_back({a, (s_held ? s_val : 32'bx)});
            end else if (n1 == 0) begin
                exp_q.push_back(64'bx);
            end else begin
                a = m0.pop_front();
                b = m1.pop_front();
                exp_q.push_back({a, b});
            end
        end
        if (!rst_n) begin
            m0.delete();
            m1.delete();
            s_held = 1'b0;
            s_val  = 32'd0;
        end else begin
            if (in0_valid && n0 < 2) m0.push_back(in0);
            if (in1_valid && !config_sig[0]) begin
                if (config_sig == 2'd2) begin
                    if (!s_held) begin
                        s_held = 1'b1;
                        s_val  = in1;
                    end
                end else if (n1 < 2) begin
                    m1.push_back(in1);
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset(input logic [1:0] cfg);
        rst_n = 1'b0;
        config_sig = cfg;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        config_sig = 2'd0;
        out_ready = 1'b1;
        in0 = 32'hAAAA_0001;
        in1 = 32'hBBBB_0002;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        s_held = 1'b0;
        s_val = 32'd0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got %b%b exp 00", in0_ready, in1_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out0 !== 32'd0 || out1 !== 32'd0) begin
            failures++;
            $display("FAIL reset_out got v=%b %h %h exp v=0 0 0", out_valid, out0, out1);
        end
        rst_n = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        #1;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_ready got %b%b exp 11", in0_ready, in1_ready);
        end
        @(negedge clk);
        cyc++;
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_fire got %0d fires exp 0", obs_q.size());
        end
    endtask

    task automatic test_normal_join();
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
        out_ready = 1'b1;
        in0 = 32'd5; in0_valid = 1'b1;
        tick();
        in0_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL join_early_valid got %b exp 0", out_valid);
            end
            tick();
        end
        in1 = 32'd7; in1_valid = 1'b1;
        tick();
        in1_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out0 !== 32'd5 || out1 !== 32'd7) begin
            failures++;
            $display("FAIL join_pair got v=%b (%0d,%0d) exp v=1 (5,7)", out_valid, out0, out1);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL join_count got %0d exp 1", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL join_sb[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
        out_ready = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            in0 = 32'(v); in1 = 32'(v);
            in0_valid = 1'b1; in1_valid = 1'b1;
            #1;
            checks++;
            if (in0_ready !== (v <= 2) || in1_ready !== (v <= 2)) begin
                failures++;
                $display("FAIL bp_ready[%0d] got %b%b exp %b%b", v, in0_ready, in1_ready, v <= 2, v <= 2);
            end
            tick();
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out0 !== 32'd1 || out1 !== 32'd1) begin
            failures++;
            $display("FAIL bp_hold got v=%b (%0d,%0d) exp v=1 (1,1)", out_valid, out0, out1);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_back got %b%b exp 11", in0_ready, in1_ready);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== {32'd1, 32'd1} || obs_q[1] !== {32'd2, 32'd2}) begin
            failures++;
            $display("FAIL bp_pairs got n=%0d exp n=2 (1,1),(2,2)", obs_q.size());
        end else begin
            checks++;
            if (obs_cyc[1] != obs_cyc[0] + 1) begin
                failures++;
                $display("FAIL bp_consecutive got cycles %0d,%0d exp adjacent", obs_cyc[0], obs_cyc[1]);
            end
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_sb[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_streaming();
        logic [63:0] want;
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in0 = 32'(i); in1 = 32'(i);
            in0_valid = 1'b1; in1_valid = 1'b1;
            tick();
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (obs_q.size() != 16) begin
            failures++;
            $display("FAIL stream_count got %0d exp 16", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            want = {32'(i), 32'(i)};
            checks++;
            if (obs_q[i] !== want || obs_q[i] !== exp_q[i] || obs_cyc[i] != obs_cyc[0] + i) begin
                failures++;
                $display("FAIL stream[%0d] got %h @%0d exp %h @%0d", i, obs_q[i], obs_cyc[i], want, obs_cyc[0] + i);
            end
        end
    endtask

    task automatic test_sticky();
        apply_reset(2'd2);
        out_ready = 1'b1;
        in1 = 32'd100; in1_valid = 1'b1;
        tick();
        in1 = 32'd555;
        #1;
        checks++;
        if (in1_ready !== 1'b0) begin
            failures++;
            $display("FAIL sticky_ready got %b exp 0", in1_ready);
        end
        for (int v = 1; v <= 3; v++) begin
            in0 = 32'(v); in0_valid = 1'b1;
            tick();
            checks++;
            if (in1_ready !== 1'b0) begin
                failures++;
                $display("FAIL sticky_ready_hold[%0d] got %b exp 0", v, in1_ready);
            end
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (obs_q.size() != 3) begin
            failures++;
            $display("FAIL sticky_count got %0d exp 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== {32'(i + 1), 32'd100} || obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL sticky[%0d] got %h exp %h", i, obs_q[i], {32'(i + 1), 32'd100});
            end
        end
    endtask

    task automatic test_single_reset();
        apply_reset(2'd1);
        out_ready = 1'b1;
        in0 = 32'd9; in0_valid = 1'b1;
        in1 = 32'd77; in1_valid = 1'b1;
        #1;
        checks++;
        if (in1_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_in1_ready got %b exp 0", in1_ready);
        end
        tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out0 !== 32'd9 || out1 !== 32'd0) begin
            failures++;
            $display("FAIL single_pair got v=%b (%0d,%0d) exp v=1 (9,0)", out_valid, out0, out1);
        end
        for (int i = 0; i < 2; i++) tick();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL single_sb got n=%0d exp n=1 pair (9,0)", obs_q.size());
        end
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
        out_ready = 1'b0;
        for (int v = 11; v <= 12; v++) begin
            in0 = 32'(v); in0_valid = 1'b1;
            tick();
        end
        in0_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out0 !== 32'd11) begin
            failures++;
            $display("FAIL single_queued got v=%b %0d exp v=1 11", out_valid, out0);
        end
        out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out0 !== 32'd0 || in0_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_after_reset got v=%b out0=%0d rdy=%b exp v=0 out0=0 rdy=1", out_valid, out0, in0_ready);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL single_stale got %0d fires exp 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_normal_join();
        test_backpressure();
        test_streaming();
        test_sticky();
        test_single_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
